// File: rtl/bram_loader_rv32_pkg.sv
// Shared types and helpers for the byte-stream to 32-bit RAM loader.
package bram_loader_rv32_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    VERIFY,
    DONE
  } state_t;

  // Number of filled lanes (0..4) to a byte-enable mask.
  function automatic logic [3:0] lane_mask(input logic [2:0] lanes);
    logic [3:0] m;
    m = '0;
    case (lanes)
      3'd0:    m = 4'b0000;
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] b;
    b = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      b[8*k +: 8] = {8{m[k]}};
    end
    return b;
  endfunction

endpackage

// File: rtl/bram_loader_rv32_packer.sv
// Little-endian byte-to-word assembler; tracks how many lanes are filled.
module loader_word_packer
  import bram_loader_rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [2:0]  lanes,
  output logic [3:0]  mask
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word  <= '0;
      lanes <= '0;
    end else if (accept && lanes < 3'd4) begin
      word[{lanes[1:0], 3'b000} +: 8] <= data;
      lanes                           <= lanes + 3'd1;
    end
  end

  assign mask = lane_mask(lanes);

endmodule

// File: rtl/bram_loader_rv32.sv
// Loads a byte stream into a RAM window as 32-bit words, then reads the
// window back and reports an XOR checksum of what landed.
module bram_loader_rv32
  import bram_loader_rv32_pkg::*;
#(
  parameter int unsigned BaseAddress   = 0,
  parameter int unsigned EndAddress    = 255,
  parameter int unsigned address_width = 32,
  parameter int unsigned data_width    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [address_width-1:0] byte_count,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic [address_width-1:0] mem_addr,
  output logic [3:0]               mem_wr,
  output logic [data_width-1:0]    mem_wdata,
  input  logic [data_width-1:0]    mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [data_width-1:0]    checksum
);

  localparam logic [address_width-1:0] BASE   = address_width'(BaseAddress);
  localparam logic [address_width-1:0] WINDOW = address_width'(EndAddress - BaseAddress + 1);
  localparam logic [address_width-1:0] ONE    = address_width'(1);
  localparam logic [address_width-1:0] FOUR   = address_width'(4);

  state_t state, next_state;

  logic [address_width-1:0] ptr;
  logic [address_width-1:0] remaining;
  logic [address_width-1:0] words;
  logic [address_width-1:0] rd_idx;
  logic [address_width-1:0] rd_addr;
  logic [3:0]               last_mask;

  logic        accept;
  logic        word_end;
  logic        clear;
  logic [31:0] word;
  logic [2:0]  lanes;
  logic [3:0]  mask;

  assign accept   = (state == COLLECT) && in_valid;
  assign word_end = accept && ((lanes == 3'd3) || (remaining == ONE));

  loader_word_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .accept (accept),
    .data   (in_data),
    .word   (word),
    .lanes  (lanes),
    .mask   (mask)
  );

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    mem_addr   = BASE;
    mem_wr     = '0;
    mem_wdata  = '0;
    done       = 1'b0;
    clear      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          if (byte_count == '0)         next_state = DONE;
          else if (byte_count <= WINDOW) next_state = COLLECT;
        end
      end
      COLLECT: begin
        in_ready = 1'b1;
        mem_addr = ptr;
        if (word_end) next_state = WRITE;
      end
      WRITE: begin
        mem_addr   = ptr;
        mem_wr     = mask;
        mem_wdata  = word;
        clear      = 1'b1;
        next_state = (remaining != '0) ? COLLECT : VERIFY;
      end
      VERIFY: begin
        mem_addr = rd_addr;
        if (rd_idx == words) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= BASE;
      remaining <= '0;
      words     <= '0;
      rd_idx    <= '0;
      rd_addr   <= BASE;
      last_mask <= '0;
      checksum  <= '0;
      error     <= 1'b0;
    end else begin
      state <= next_state;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (byte_count > WINDOW) begin
              error <= 1'b1;
            end else begin
              remaining <= byte_count;
              words     <= (byte_count >> 2) + address_width'(|byte_count[1:0]);
              last_mask <= lane_mask((byte_count[1:0] == 2'd0) ? 3'd4 : {1'b0, byte_count[1:0]});
              checksum  <= '0;
              ptr       <= BASE;
            end
          end
        end
        COLLECT: begin
          if (accept && remaining != '0) remaining <= remaining - ONE;
        end
        WRITE: begin
          ptr     <= ptr + FOUR;
          rd_idx  <= '0;
          rd_addr <= BASE;
        end
        VERIFY: begin
          // Read data lags the address by one cycle: index i captures word i-1.
          if (rd_idx != words) rd_idx <= rd_idx + ONE;
          rd_addr <= rd_addr + FOUR;
          if (rd_idx != '0) begin
            checksum <= checksum ^ (mem_rdata & ((rd_idx == words) ? lane_bits(last_mask) : '1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bram_loader_rv32.md
BRAM_LOADER_RV32 -- requirements
Module: bram_loader_rv32

Interface
REQ-001 Parameter BaseAddress, default 0: first byte address of target RAM window; word-aligned.
REQ-002 Parameter EndAddress, default 255: last byte address of target RAM window, inclusive.
REQ-003 Parameter address_width, default 32: width of mem_addr and byte_count.
REQ-004 Parameter data_width, default 32: bus word width; only 32 is supported.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle load request; sampled only in IDLE.
REQ-008 byte_count  input  address_width  bytes to load; sampled with start.
REQ-009 in_valid  input  1  stream byte valid.
REQ-010 in_data  input  8  stream byte.
REQ-011 in_ready  output  1  loader accepts byte; a transfer occurs on in_valid & in_ready.
REQ-012 mem_addr  output  address_width  byte address to RAM bus.
REQ-013 mem_wr  output  4  per-lane byte write enables.
REQ-014 mem_wdata  output  32  write data.
REQ-015 mem_rdata  input  32  RAM read data; valid one cycle after mem_addr is presented.
REQ-016 busy  output  1  high from the cycle after an accepted start until DONE is exited.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 error  output  1  one-cycle pulse on a rejected start.
REQ-019 checksum  output  32  XOR of all read-back words; held from done until the next accepted start.

Function
REQ-020 The FSM SHALL have states IDLE, COLLECT, WRITE, VERIFY, DONE.
REQ-021 IDLE: start=1 with 0 < byte_count <= EndAddress-BaseAddress+1 SHALL latch the count, clear the checksum, set the write pointer to BaseAddress, and enter COLLECT next cycle.
REQ-022 IDLE: start=1 with byte_count == 0 SHALL enter DONE (done pulse, checksum 0) without any bus access.
REQ-023 IDLE: start=1 with byte_count larger than the window SHALL pulse error next cycle, stay in IDLE, and make no bus access.
REQ-024 COLLECT: in_ready SHALL be 1; the k-th accepted byte of a word (k=0..3) SHALL go to lane k, bits [8k+7:8k], little-endian.
REQ-025 COLLECT SHALL go to WRITE on the cycle that the 4th byte of a word or the final byte of the count is accepted.
REQ-026 WRITE (one cycle): mem_addr = pointer, mem_wr = mask of filled lanes, mem_wdata = assembled word with unfilled lanes zero; in_ready = 0.
REQ-027 After WRITE the pointer SHALL advance by 4; the FSM SHALL go to COLLECT if bytes remain, else to VERIFY.
REQ-028 VERIFY SHALL present word addresses BaseAddress, +4, ... one per cycle with mem_wr = 0, and capture mem_rdata one cycle later (pipelined).
REQ-029 VERIFY SHALL XOR each captured word into checksum, with the final word masked to its filled lanes.
REQ-030 VERIFY SHALL exit to DONE on the cycle after the last read data is captured; total VERIFY length = words + 1 cycles.
REQ-031 DONE SHALL assert done for one cycle and return to IDLE.
REQ-032 start SHALL be ignored when not in IDLE.
REQ-033 mem_wr SHALL be 0 in every state except WRITE.
REQ-034 mem_addr SHALL be BaseAddress when idle.
REQ-035 Remaining-byte and word counters SHALL be address_width wide and never wrap.

Reset
REQ-036 Reset SHALL force IDLE and drive in_ready, mem_wr, busy, done, error to 0, mem_addr to BaseAddress, and mem_wdata and checksum to 0.
REQ-037 Reset mid-transfer SHALL abort the load with no done pulse and no further writes; bytes already written remain in RAM.

Structure
REQ-038 A shared package SHALL hold the state enum and the helper that turns a lane count into a byte-enable mask.
REQ-039 The design SHALL contain one sub-module, loader_word_packer, which performs byte-to-word assembly and lane-mask generation.

Verification
REQ-040 byte_count=8, bytes 01..08 -> writes 0x04030201 @Base mask F, then 0x08070605 @Base+4 mask F; checksum 0x0C040404; done.
REQ-041 byte_count=5, bytes AA BB CC DD EE -> second write 0x000000EE with mask 1; checksum 0xDDCCBB44.
REQ-042 Stream stalls: in_valid toggling every other cycle -> identical writes and checksum to the non-stalled run; in_ready is 0 during WRITE.
REQ-043 byte_count=0 -> done pulse with no mem_wr activity and checksum 0; byte_count=Window+1 -> error pulse, busy stays 0.
REQ-044 Reset asserted after 3 bytes -> no write and no done; all outputs are at reset values next cycle; a following load of 4 bytes completes normally.
REQ-045 start pulsed during COLLECT -> ignored, and the load result is unchanged.
